// File: rtl/minbd_pkg.sv
// Shared MinBD router definitions: flit geometry, port count, slot naming
// and a lowest-index one-hot picker used for slot and deflection arbitration.
package minbd_pkg;

  localparam int FLIT_W    = 11;
  localparam int VALID_BIT = FLIT_W - 1;
  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    SLOT_N = 2'd0,
    SLOT_S = 2'd1,
    SLOT_W = 2'd2,
    SLOT_E = 2'd3
  } slot_e;

  typedef logic [FLIT_W-1:0] flit_t;

  // Isolates the lowest set bit of req; all-zero in, all-zero out.
  function automatic logic [NUM_PORTS-1:0] pick_lowest(input logic [NUM_PORTS-1:0] req);
    return req & (~req + NUM_PORTS'(1));
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Side-buffer storage: DEPTH-entry synchronous FIFO with simultaneous
// push/pop (legal when full), occupancy count and combinational head.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears pointers/count)
//   push_i      write wdata_i at the tail this cycle
//   pop_i       retire the head this cycle
//   wdata_i     flit to enqueue
//   head_o      current head entry (undefined while empty)
//   full_o      DEPTH entries held
//   empty_o     no entries held
//   count_o     occupancy, 0..DEPTH
module sb_fifo import minbd_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  flit_t                    wdata_i,
  output flit_t                    head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  flit_t              mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  // With push and pop together while full, wr_ptr == rd_ptr: the head is
  // read combinationally this cycle and overwritten at the edge, so the
  // new flit lands behind the remaining entries.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/side_buffer_ctrl.sv
// MinBD side-buffer controller. Captures one deflected flit per cycle from
// the deflection network outputs, re-injects buffered flits into free input
// slots, and forces a redirect swap after STARVE_LIMIT starved cycles.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   slot_in     router input-stage flits, slot k at [k*FLIT_W +: FLIT_W]
//   slot_out    flits towards the deflection network (head may be injected)
//   pdn_in      deflection network outputs
//   defl_mask   per-slot deflected flag for pdn_in
//   pdn_fwd     network outputs to link registers (captured slot zeroed)
//   buf_count   side-buffer occupancy
//   redirect    swap of the head with the slot_in N flit this cycle
module side_buffer_ctrl import minbd_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*FLIT_W-1:0]   slot_in,
  output logic [NUM_PORTS*FLIT_W-1:0]   slot_out,
  input  logic [NUM_PORTS*FLIT_W-1:0]   pdn_in,
  input  logic [NUM_PORTS-1:0]          defl_mask,
  output logic [NUM_PORTS*FLIT_W-1:0]   pdn_fwd,
  output logic [$clog2(DEPTH):0]        buf_count,
  output logic                          redirect
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]          starve_q, starve_d;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  flit_t                  fifo_head, fifo_wdata, captured;
  logic [NUM_PORTS-1:0]   free_mask, defl_cand, free_pick, cap_pick;
  logic                   starved, reinject, cap_en;

  always_comb begin
    free_mask = '0;
    defl_cand = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      free_mask[k] = ~slot_in[k*FLIT_W + VALID_BIT];
      defl_cand[k] = defl_mask[k] & pdn_in[k*FLIT_W + VALID_BIT];
    end
    free_pick = pick_lowest(free_mask);
    cap_pick  = pick_lowest(defl_cand);

    starved  = (starve_q == SW'(STARVE_LIMIT));
    reinject = !rst && !fifo_empty && (|free_mask);
    // No free slot means every slot_in is valid, so N is the lowest valid one.
    redirect = !rst && !fifo_empty && starved && (free_mask == '0);
    fifo_pop = reinject || redirect;
    cap_en   = !rst && !redirect && (!fifo_full || fifo_pop) && (|defl_cand);

    slot_out = slot_in;
    pdn_fwd  = pdn_in;
    captured = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (reinject && free_pick[k]) slot_out[k*FLIT_W +: FLIT_W] = fifo_head;
      if (cap_en && cap_pick[k]) begin
        captured                     = pdn_in[k*FLIT_W +: FLIT_W];
        pdn_fwd[k*FLIT_W +: FLIT_W]  = '0;
      end
    end
    if (redirect) slot_out[int'(SLOT_N)*FLIT_W +: FLIT_W] = fifo_head;

    fifo_push  = redirect || cap_en;
    fifo_wdata = redirect ? slot_in[int'(SLOT_N)*FLIT_W +: FLIT_W] : captured;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) starve_d = '0;
    else if (!starved)          starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (buf_count)
  );

endmodule
